// File: rtl/codec_clock_monitor.sv
// Measures the codec LRCLK period and BCLK edges per frame in the system clock domain.
// Optional build macro CLKMON_STICKY_LOST_EN keeps o_clock_lost set until reset.
module codec_clock_monitor #(
  parameter int EXP_BCLK_PER_FRAME = 64,
  parameter int PERIOD_TOL         = 8,
  parameter int LOCK_COUNT         = 4,
  parameter int TIMEOUT_CYCLES     = 4096
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_bclk,
  input  logic        i_lrclk,
  output logic [15:0] o_frame_period,
  output logic [7:0]  o_bclk_count,
  output logic        o_valid,
  output logic        o_locked,
  output logic        o_clock_lost,
  output logic [7:0]  o_error_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    EXP_COUNT    = 8'(EXP_BCLK_PER_FRAME);
  localparam logic [15:0]   TOL          = 16'(PERIOD_TOL);
  localparam logic [3:0]    LOCK_THRESH  = 4'(LOCK_COUNT);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_ACQUIRE,
    ST_MEASURE,
    ST_TRACK
  } state_t;

  // ---------------------------------------------------------------
  // Input synchronizers: bit 0 = BCLK, bit 1 = LRCLK
  // ---------------------------------------------------------------
  logic [1:0] pin_async;
  logic [1:0] pin_rise;
  logic [1:0] warm_reg;
  logic       warm_done;

  assign pin_async = {i_lrclk, i_bclk};
  assign warm_done = (warm_reg == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      logic s3_reg;

      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
          s3_reg <= 1'b0;
        end else begin
          s1_reg <= pin_async[gi];
          s2_reg <= s1_reg;
          s3_reg <= s2_reg;
        end
      end

      assign pin_rise[gi] = warm_done & s2_reg & ~s3_reg;
    end
  endgenerate

  // Edges are ignored until the history flop holds real pin data.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      warm_reg <= 2'd0;
    end else if (!warm_done) begin
      warm_reg <= warm_reg + 2'd1;
    end
  end

  logic lr_edge;
  logic bc_edge;
  assign lr_edge = pin_rise[1];
  assign bc_edge = pin_rise[0];

  // ---------------------------------------------------------------
  // Free-running frame counters
  // ---------------------------------------------------------------
  logic [15:0]   period_cnt_reg, period_cnt_next;
  logic [7:0]    bclk_cnt_reg, bclk_cnt_next;
  logic [TW-1:0] timeout_reg, timeout_next;

  always_comb begin
    period_cnt_next = period_cnt_reg;
    bclk_cnt_next   = bclk_cnt_reg;
    timeout_next    = timeout_reg;
    if (lr_edge) begin
      period_cnt_next = 16'd1;
      bclk_cnt_next   = {7'd0, bc_edge};
      timeout_next    = '0;
    end else begin
      if (period_cnt_reg != 16'hFFFF) period_cnt_next = period_cnt_reg + 16'd1;
      if (bc_edge && bclk_cnt_reg != 8'hFF) bclk_cnt_next = bclk_cnt_reg + 8'd1;
      if (timeout_reg != TIMEOUT_MAX) timeout_next = timeout_reg + TW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Frame qualification and tracking FSM
  // ---------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [15:0] frame_period_reg, frame_period_next;
  logic [7:0]  bclk_count_reg, bclk_count_next;
  logic        valid_reg, valid_next;
  logic        locked_reg, locked_next;
  logic        lost_reg, lost_next;
  logic [7:0]  error_count_reg, error_count_next;
  logic [3:0]  good_cnt_reg, good_cnt_next;

  logic [15:0] period_delta;
  logic        count_ok;
  logic        period_ok;
  logic        frame_good;
  logic        timeout_hit;
  logic [3:0]  good_inc;

  // The previously latched period doubles as the reference for jitter.
  assign period_delta = (period_cnt_reg >= frame_period_reg) ?
                        (period_cnt_reg - frame_period_reg) :
                        (frame_period_reg - period_cnt_reg);
  assign count_ok     = (bclk_cnt_reg == EXP_COUNT);
  assign period_ok    = (period_delta <= TOL);
  assign frame_good   = count_ok & ((state_reg == ST_MEASURE) | period_ok);
  assign good_inc     = (good_cnt_reg == 4'hF) ? good_cnt_reg : good_cnt_reg + 4'd1;
  // Fires on the cycle the timeout counter steps onto TIMEOUT_CYCLES.
  assign timeout_hit  = (state_reg != ST_ACQUIRE) && !lr_edge && (timeout_reg == TIMEOUT_LAST);

  always_comb begin
    state_next        = state_reg;
    frame_period_next = frame_period_reg;
    bclk_count_next   = bclk_count_reg;
    valid_next        = 1'b0;
    locked_next       = locked_reg;
    lost_next         = lost_reg;
    error_count_next  = error_count_reg;
    good_cnt_next     = good_cnt_reg;

    case (state_reg)
      ST_ACQUIRE: begin
        if (lr_edge) state_next = ST_MEASURE;
      end
      ST_MEASURE, ST_TRACK: begin
        if (lr_edge) begin
          frame_period_next = period_cnt_reg;
          bclk_count_next   = bclk_cnt_reg;
          valid_next        = 1'b1;
          state_next        = ST_TRACK;
          if (frame_good) begin
            good_cnt_next = good_inc;
            if (good_inc >= LOCK_THRESH) locked_next = 1'b1;
          end else begin
            good_cnt_next = 4'd0;
            locked_next   = 1'b0;
            if (error_count_reg != 8'hFF) error_count_next = error_count_reg + 8'd1;
          end
        end else if (timeout_hit) begin
          lost_next     = 1'b1;
          locked_next   = 1'b0;
          good_cnt_next = 4'd0;
          state_next    = ST_ACQUIRE;
        end
      end
      default: state_next = ST_ACQUIRE;
    endcase

`ifdef CLKMON_STICKY_LOST_EN
    // Loss indication is held until reset; acquisition restarts regardless.
`else
    if (lr_edge) lost_next = 1'b0;
`endif
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg        <= ST_ACQUIRE;
      period_cnt_reg   <= 16'd0;
      bclk_cnt_reg     <= 8'd0;
      timeout_reg      <= '0;
      frame_period_reg <= 16'd0;
      bclk_count_reg   <= 8'd0;
      valid_reg        <= 1'b0;
      locked_reg       <= 1'b0;
      lost_reg         <= 1'b0;
      error_count_reg  <= 8'd0;
      good_cnt_reg     <= 4'd0;
    end else begin
      state_reg        <= state_next;
      period_cnt_reg   <= period_cnt_next;
      bclk_cnt_reg     <= bclk_cnt_next;
      timeout_reg      <= timeout_next;
      frame_period_reg <= frame_period_next;
      bclk_count_reg   <= bclk_count_next;
      valid_reg        <= valid_next;
      locked_reg       <= locked_next;
      lost_reg         <= lost_next;
      error_count_reg  <= error_count_next;
      good_cnt_reg     <= good_cnt_next;
    end
  end

  assign o_frame_period = frame_period_reg;
  assign o_bclk_count   = bclk_count_reg;
  assign o_valid        = valid_reg;
  assign o_locked       = locked_reg;
  assign o_clock_lost   = lost_reg;
  assign o_error_count  = error_count_reg;

endmodule

// File: tb/tb_codec_clock_monitor.sv
// Randomized self-checking bench for codec_clock_monitor; frames are described as
// (period, bclk edges) and a frame-level reference model predicts every report.
module tb_codec_clock_monitor;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_bclk;
  logic        i_lrclk;
  logic [15:0] o_frame_period;
  logic [7:0]  o_bclk_count;
  logic        o_valid;
  logic        o_locked;
  logic        o_clock_lost;
  logic [7:0]  o_error_count;

  always #5 clk = ~clk;

  codec_clock_monitor dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_bclk         (i_bclk),
    .i_lrclk        (i_lrclk),
    .o_frame_period (o_frame_period),
    .o_bclk_count   (o_bclk_count),
    .o_valid        (o_valid),
    .o_locked       (o_locked),
    .o_clock_lost   (o_clock_lost),
    .o_error_count  (o_error_count)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] period;
    logic [7:0]  bcnt;
    logic        locked;
    logic [7:0]  err;
  } rep_t;

  rep_t exp_q[$];
  rep_t obs_q[$];
  rep_t obs_r;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   lost_cyc = -1;
  logic lost_d = 1'b0;

  // Reference model state (frame level)
  int m_state;     // 0 acquire, 1 first frame being measured, 2 tracking
  int m_prev_p;
  int m_pend_p;
  int m_pend_n;
  int m_good;
  int m_err;
  int m_last_edge;
  bit m_locked;
  bit m_lost;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (o_valid) begin
      obs_r.cyc    = cyc;
      obs_r.period = o_frame_period;
      obs_r.bcnt   = o_bclk_count;
      obs_r.locked = o_locked;
      obs_r.err    = o_error_count;
      obs_q.push_back(obs_r);
    end
    if (o_clock_lost && !lost_d) lost_cyc = cyc;
    lost_d = o_clock_lost;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_state = 0; m_prev_p = 0; m_pend_p = 0; m_pend_n = 0;
    m_good = 0; m_err = 0; m_locked = 0; m_lost = 0; m_last_edge = 0;
    exp_q.delete();
  endfunction

  // A new frame starts at drive cycle ecyc; the frame before it gets reported.
  function automatic void model_edge(input int p, input int n, input int ecyc);
    int   cnt;
    int   d;
    bit   good;
    rep_t r;
    if (m_state == 0) begin
      m_state = 1;
    end else begin
      cnt  = (m_pend_n > 255) ? 255 : m_pend_n;
      d    = m_pend_p - m_prev_p;
      if (d < 0) d = -d;
      good = (cnt == 64) && (m_state == 1 || d <= 8);
      if (good) begin
        m_good = (m_good < 15) ? m_good + 1 : 15;
        if (m_good >= 4) m_locked = 1;
      end else begin
        m_good   = 0;
        m_locked = 0;
        m_err    = (m_err < 255) ? m_err + 1 : 255;
      end
      m_prev_p = m_pend_p;
      r.cyc = ecyc + 3; r.period = m_pend_p[15:0]; r.bcnt = cnt[7:0];
      r.locked = m_locked; r.err = m_err[7:0];
      exp_q.push_back(r);
      m_state = 2;
    end
`ifndef CLKMON_STICKY_LOST_EN
    m_lost = 0;
`endif
    m_pend_p = p;
    m_pend_n = n;
    m_last_edge = ecyc;
  endfunction

  // Drives cycles [c0, c1) of a frame of p cycles with n evenly spaced BCLK rises.
  task automatic drive_span(input int p, input int n, input int c0, input int c1);
    int sp;
    sp = p / n;
    for (int c = c0; c < c1; c++) begin
      @(negedge clk);
      if (c == 0) model_edge(p, n, cyc);
      i_lrclk = (c < p / 2);
      i_bclk  = (c < n * sp) && ((c % sp) < sp / 2);
    end
  endtask

  task automatic drive_frame(input int p, input int n);
    drive_span(p, n, 0, p);
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_bclk = 1'b0; i_lrclk = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    n_cmp++; if (o_frame_period !== 16'd0) begin n_bad++; $display("FAIL reset_period got %0d want 0", o_frame_period); end
    n_cmp++; if (o_bclk_count !== 8'd0) begin n_bad++; $display("FAIL reset_bclk got %0d want 0", o_bclk_count); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", o_valid); end
    n_cmp++; if (o_locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got %0b want 0", o_locked); end
    n_cmp++; if (o_clock_lost !== 1'b0) begin n_bad++; $display("FAIL reset_lost got %0b want 0", o_clock_lost); end
    n_cmp++; if (o_error_count !== 8'd0) begin n_bad++; $display("FAIL reset_errcnt got %0d want 0", o_error_count); end
    i_reset = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL reset_idle_valids got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_nominal();
    repeat (5) drive_frame(2048, 64);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL nominal_reports got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL nominal_rep%0d got cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d want cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d", i, obs_q[i].cyc, obs_q[i].period, obs_q[i].bcnt, obs_q[i].locked, obs_q[i].err, exp_q[i].cyc, exp_q[i].period, exp_q[i].bcnt, exp_q[i].locked, exp_q[i].err); end
    end
    obs_q.delete(); exp_q.delete();
    n_cmp++; if (o_locked !== 1'b1) begin n_bad++; $display("FAIL nominal_locked got %0b want 1", o_locked); end
  endtask

  task automatic test_count_error();
    drive_frame(2048, 63);
    repeat (5) drive_frame(2048, 64);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL counterr_reports got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL counterr_rep%0d got cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d want cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d", i, obs_q[i].cyc, obs_q[i].period, obs_q[i].bcnt, obs_q[i].locked, obs_q[i].err, exp_q[i].cyc, exp_q[i].period, exp_q[i].bcnt, exp_q[i].locked, exp_q[i].err); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_jitter();
    drive_frame(2055, 64);
    drive_frame(2048, 64);
    drive_frame(2055, 64);
    drive_frame(2048, 64);
    drive_frame(2060, 64);
    drive_frame(2048, 64);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL jitter_reports got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL jitter_rep%0d got cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d want cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d", i, obs_q[i].cyc, obs_q[i].period, obs_q[i].bcnt, obs_q[i].locked, obs_q[i].err, exp_q[i].cyc, exp_q[i].period, exp_q[i].bcnt, exp_q[i].locked, exp_q[i].err); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_loss();
    int exp_lost;
    exp_lost = m_last_edge + 3 + 4096;
    lost_cyc = -1;
    repeat (4200) begin
      @(negedge clk);
      i_lrclk = 1'b0;
      i_bclk  = 1'b0;
    end
    m_state = 0; m_good = 0; m_locked = 0; m_lost = 1;
    n_cmp++; if (lost_cyc !== exp_lost) begin n_bad++; $display("FAIL loss_time got %0d want %0d", lost_cyc, exp_lost); end
    n_cmp++; if (o_clock_lost !== 1'b1) begin n_bad++; $display("FAIL loss_flag got %0b want 1", o_clock_lost); end
    n_cmp++; if (o_locked !== 1'b0) begin n_bad++; $display("FAIL loss_locked got %0b want 0", o_locked); end
    n_cmp++; if (o_frame_period !== m_prev_p[15:0]) begin n_bad++; $display("FAIL loss_hold_period got %0d want %0d", o_frame_period, m_prev_p); end
    n_cmp++; if (o_error_count !== m_err[7:0]) begin n_bad++; $display("FAIL loss_errcnt got %0d want %0d", o_error_count, m_err); end
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL loss_valids got %0d want 0", obs_q.size()); end
    drive_span(2048, 64, 0, 20);
    n_cmp++; if (o_clock_lost !== m_lost) begin n_bad++; $display("FAIL restart_lost got %0b want %0b", o_clock_lost, m_lost); end
    drive_span(2048, 64, 20, 2048);
    repeat (2) drive_frame(2048, 64);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL restart_reports got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL restart_rep%0d got cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d want cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d", i, obs_q[i].cyc, obs_q[i].period, obs_q[i].bcnt, obs_q[i].locked, obs_q[i].err, exp_q[i].cyc, exp_q[i].period, exp_q[i].bcnt, exp_q[i].locked, exp_q[i].err); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturation();
    drive_frame(2048, 300);
    drive_frame(2048, 64);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL sat_reports got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL sat_rep%0d got cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d want cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d", i, obs_q[i].cyc, obs_q[i].period, obs_q[i].bcnt, obs_q[i].locked, obs_q[i].err, exp_q[i].cyc, exp_q[i].period, exp_q[i].bcnt, exp_q[i].locked, exp_q[i].err); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    drive_span(2048, 64, 0, 1034);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    model_reset();
    obs_q.delete();
    n_cmp++; if (o_frame_period !== 16'd0) begin n_bad++; $display("FAIL midrst_period got %0d want 0", o_frame_period); end
    n_cmp++; if (o_bclk_count !== 8'd0) begin n_bad++; $display("FAIL midrst_bclk got %0d want 0", o_bclk_count); end
    n_cmp++; if (o_locked !== 1'b0) begin n_bad++; $display("FAIL midrst_locked got %0b want 0", o_locked); end
    n_cmp++; if (o_clock_lost !== 1'b0) begin n_bad++; $display("FAIL midrst_lost got %0b want 0", o_clock_lost); end
    n_cmp++; if (o_error_count !== 8'd0) begin n_bad++; $display("FAIL midrst_errcnt got %0d want 0", o_error_count); end
    i_reset = 1'b0;
    drive_span(2048, 64, 1036, 2048);
    repeat (3) drive_frame(2048, 64);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL midrst_reports got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL midrst_rep%0d got cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d want cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d", i, obs_q[i].cyc, obs_q[i].period, obs_q[i].bcnt, obs_q[i].locked, obs_q[i].err, exp_q[i].cyc, exp_q[i].period, exp_q[i].bcnt, exp_q[i].locked, exp_q[i].err); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int p;
    int r;
    int n;
    for (int k = 0; k < 8; k++) begin
      p = $urandom_range(2058, 2040);
      r = $urandom_range(9, 0);
      n = (r < 7) ? 64 : ((r == 7) ? 63 : 65);
      drive_frame(p, n);
    end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL random_reports got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL random_rep%0d got cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d want cyc=%0d per=%0d bclk=%0d lock=%0b err=%0d", i, obs_q[i].cyc, obs_q[i].period, obs_q[i].bcnt, obs_q[i].locked, obs_q[i].err, exp_q[i].cyc, exp_q[i].period, exp_q[i].bcnt, exp_q[i].locked, exp_q[i].err); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_count_error();
    test_jitter();
    test_loss();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
